// File: rtl/segre_pkg.sv
// Shared parameters and access-size type for the segre L1 data cache.
package segre_pkg;

    localparam int unsigned WORD_SIZE         = 32;
    localparam int unsigned DCACHE_LANE_SIZE  = 128;
    localparam int unsigned DCACHE_INDEX_SIZE = 2;
    localparam int unsigned DCACHE_BYTE_SIZE  = 4;
    localparam int unsigned DCACHE_TAG_SIZE   = 26;

    localparam int unsigned DCACHE_LANES      = 1 << DCACHE_INDEX_SIZE;
    localparam int unsigned DCACHE_LANE_BYTES = DCACHE_LANE_SIZE / 8;
    localparam int unsigned WORD_BYTES        = WORD_SIZE / 8;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memop_data_type_e;

endpackage

// File: rtl/segre_dcache_data_array_if.sv
// LSU/MMU request bus of the dcache data array.
interface segre_dcache_data_array_if;
    import segre_pkg::*;

    logic                        rd_data_i;
    logic                        wr_data_i;
    logic                        mem_wr_data_i;
    logic [WORD_SIZE-1:0]        addr_i;
    memop_data_type_e            memop_data_type_i;
    logic [WORD_SIZE-1:0]        data_i;
    logic [DCACHE_LANE_SIZE-1:0] mem_data_i;
    logic [WORD_SIZE-1:0]        data_o;

    modport master (
        output rd_data_i, wr_data_i, mem_wr_data_i, addr_i,
               memop_data_type_i, data_i, mem_data_i,
        input  data_o
    );

    modport slave (
        input  rd_data_i, wr_data_i, mem_wr_data_i, addr_i,
               memop_data_type_i, data_i, mem_data_i,
        output data_o
    );

endinterface

// File: rtl/segre_dcache_byte_sel.sv
// Byte-lane steering: store byte enables / rotated store vector, and load rotation.
module segre_dcache_byte_sel
    import segre_pkg::*;
(
    input  logic [DCACHE_BYTE_SIZE-1:0] offset_i,
    input  memop_data_type_e            size_i,
    input  logic [WORD_SIZE-1:0]        wr_word_i,
    input  logic [DCACHE_LANE_SIZE-1:0] rd_lane_i,
    output logic [DCACHE_LANE_BYTES-1:0] byte_en_o,
    output logic [DCACHE_LANE_SIZE-1:0] wr_lane_o,
    output logic [WORD_SIZE-1:0]        rd_word_o
);

    logic [DCACHE_BYTE_SIZE-1:0] nbytes;

    // Number of bytes touched by the access size
    always_comb begin
        case (size_i)
            BYTE:    nbytes = DCACHE_BYTE_SIZE'(1);
            HALF:    nbytes = DCACHE_BYTE_SIZE'(2);
            default: nbytes = DCACHE_BYTE_SIZE'(4);
        endcase
    end

    // Store path: lane byte j takes data byte (j - offset) mod 16
    always_comb begin
        logic [DCACHE_BYTE_SIZE-1:0] rel;
        rel       = '0;
        byte_en_o = '0;
        wr_lane_o = '0;
        for (int unsigned j = 0; j < DCACHE_LANE_BYTES; j++) begin
            rel          = DCACHE_BYTE_SIZE'(j) - offset_i;
            byte_en_o[j] = (rel < nbytes);
            if (rel < DCACHE_BYTE_SIZE'(WORD_BYTES))
                wr_lane_o[8*j +: 8] = wr_word_i[{rel[1:0], 3'b000} +: 8];
        end
    end

    // Load path: word byte i comes from lane byte (offset + i) mod 16
    always_comb begin
        logic [DCACHE_BYTE_SIZE-1:0] pos;
        pos       = '0;
        rd_word_o = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            pos                 = offset_i + DCACHE_BYTE_SIZE'(i);
            rd_word_o[8*i +: 8] = rd_lane_i[{pos, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/segre_dcache_data_array.sv
// L1 dcache data array: 4 x 128-bit lanes, byte/half/word LSU access, lane refill.
// Optional macro SEGRE_DCACHE_BYPASS_EN: loads see same-cycle writes.
module segre_dcache_data_array
    import segre_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rsn_i,
    segre_dcache_data_array_if.slave  bus
);

    logic [DCACHE_LANE_SIZE-1:0]   lanes [DCACHE_LANES];
    logic [DCACHE_INDEX_SIZE-1:0]  idx;
    logic [DCACHE_BYTE_SIZE-1:0]   off;
    logic [DCACHE_LANE_SIZE-1:0]   cur_lane;
    logic [DCACHE_LANE_SIZE-1:0]   rd_lane;
    logic [DCACHE_LANE_SIZE-1:0]   wr_lane;
    logic [DCACHE_LANE_SIZE-1:0]   wr_mask;
    logic [DCACHE_LANE_SIZE-1:0]   lane_next;
    logic [DCACHE_LANE_BYTES-1:0]  byte_en;
    logic [WORD_SIZE-1:0]          rd_word;
    logic                          wr_en;
    logic                          unused_tag;

    assign idx        = bus.addr_i[DCACHE_BYTE_SIZE +: DCACHE_INDEX_SIZE];
    assign off        = bus.addr_i[DCACHE_BYTE_SIZE-1:0];
    assign unused_tag = ^bus.addr_i[WORD_SIZE-1:DCACHE_BYTE_SIZE+DCACHE_INDEX_SIZE];
    assign cur_lane   = lanes[idx];
    assign wr_en      = bus.mem_wr_data_i | bus.wr_data_i;

    segre_dcache_byte_sel u_byte_sel (
        .offset_i  (off),
        .size_i    (bus.memop_data_type_i),
        .wr_word_i (bus.data_i),
        .rd_lane_i (rd_lane),
        .byte_en_o (byte_en),
        .wr_lane_o (wr_lane),
        .rd_word_o (rd_word)
    );

    // Expand byte enables to a bit mask
    always_comb begin
        wr_mask = '0;
        for (int unsigned j = 0; j < DCACHE_LANE_BYTES; j++)
            wr_mask[8*j +: 8] = {8{byte_en[j]}};
    end

    // New lane contents: refill wins over a store
    always_comb begin
        if (bus.mem_wr_data_i)
            lane_next = bus.mem_data_i;
        else
            lane_next = (cur_lane & ~wr_mask) | (wr_lane & wr_mask);
    end

    // Load source lane; with bypass, same-cycle writes are forwarded
    always_comb begin
`ifdef SEGRE_DCACHE_BYPASS_EN
        rd_lane = wr_en ? lane_next : cur_lane;
`else
        rd_lane = cur_lane;
`endif
    end

    // Load output, zero when no load is requested
    always_comb begin
        bus.data_o = bus.rd_data_i ? rd_word : '0;
    end

    // Lane storage: reset clears all lanes and overrides any write
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            for (int unsigned l = 0; l < DCACHE_LANES; l++)
                lanes[l] <= '0;
        end else if (wr_en) begin
            lanes[idx] <= lane_next;
        end
    end

endmodule

// File: tb/tb_segre_dcache_data_array.sv
// Directed self-checking bench for segre_dcache_data_array (scoreboard of load results).
module tb_segre_dcache_data_array;
    import segre_pkg::*;

    logic clk = 1'b0;
    logic rsn = 1'b1;

    segre_dcache_data_array_if bus ();

    segre_dcache_data_array dut (
        .clk_i (clk),
        .rsn_i (rsn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    localparam logic [127:0] PAT  = 128'hff_ee_dd_cc_bb_aa_99_88_77_66_55_44_33_22_11_00;
    localparam logic [127:0] PAT2 = 128'h0123456789abcdef_fedcba9876543210;

    function automatic logic [31:0] mk_addr(input int unsigned idx, input int unsigned off,
                                            input logic [25:0] tag);
        return {tag, idx[1:0], off[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, check any load before the posedge, release after it
    task automatic cyc(input logic rd, input logic wr, input logic mem,
                       input logic [31:0] addr, input memop_data_type_e sz,
                       input logic [31:0] data, input logic [127:0] mdata,
                       input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        @(negedge clk);
        bus.rd_data_i         = rd;
        bus.wr_data_i         = wr;
        bus.mem_wr_data_i     = mem;
        bus.addr_i            = addr;
        bus.memop_data_type_i = sz;
        bus.data_i            = data;
        bus.mem_data_i        = mdata;
        if (rd) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        #1;
        if (rd) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, bus.data_o, e);
        end
        @(posedge clk);
        #1;
        bus.rd_data_i     = 1'b0;
        bus.wr_data_i     = 1'b0;
        bus.mem_wr_data_i = 1'b0;
    endtask

    task automatic load(input int unsigned idx, input int unsigned off,
                        input logic [31:0] exp, input string tag);
        cyc(1'b1, 1'b0, 1'b0, mk_addr(idx, off, 26'h0), WORD, 32'h0, 128'h0, exp, tag);
    endtask

    task automatic store(input int unsigned idx, input int unsigned off,
                         input memop_data_type_e sz, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, mk_addr(idx, off, 26'h0), sz, d, 128'h0, 32'h0, "");
    endtask

    task automatic refill(input int unsigned idx, input logic [127:0] md);
        cyc(1'b0, 1'b0, 1'b1, mk_addr(idx, 0, 26'h0), WORD, 32'h0, md, 32'h0, "");
    endtask

    initial begin
        bus.rd_data_i         = 1'b0;
        bus.wr_data_i         = 1'b0;
        bus.mem_wr_data_i     = 1'b0;
        bus.addr_i            = '0;
        bus.memop_data_type_i = WORD;
        bus.data_i            = '0;
        bus.mem_data_i        = '0;

        // Reset
        rsn = 1'b1;
        repeat (2) @(posedge clk);
        #1 rsn = 1'b0;
        @(negedge clk);
        check("idle_data_o", bus.data_o, 32'h0);
        load(0, 0, 32'h0, "reset_lane0");

        // Refill all lanes and word loads
        for (int unsigned l = 0; l < 4; l++) refill(l, PAT);
        load(0, 0, 32'h33221100, "refill_i0_o0");
        load(2, 0, 32'h33221100, "refill_i2_o0");
        load(3, 12, 32'hffeeddcc, "refill_i3_o12");
        cyc(1'b1, 1'b0, 1'b0, mk_addr(0, 4, 26'h3ffffff), BYTE, 32'h0, 128'h0,
            32'h77665544, "tag_ignored");

        // Unaligned loads
        load(1, 3, 32'h66554433, "unaligned_o3");
        load(1, 4, 32'h77665544, "unaligned_o4");
        load(1, 13, 32'h00ffeedd, "unaligned_wrap_o13");

        // Mixed-size stores to lane 2
        store(2, 8, WORD, 32'hcafecafe);
        store(2, 10, HALF, 32'hcafecafe);
        store(2, 12, BYTE, 32'hcafecafe);
        load(2, 8, 32'hcafecafe, "mixed_o8");
        load(2, 12, 32'hffeeddfe, "mixed_o12");
        load(2, 4, 32'h77665544, "mixed_untouched_o4");

        // Wrap store in lane 3
        store(3, 14, WORD, 32'h01020304);
        load(3, 14, 32'h01020304, "wrap_o14");
        load(3, 0, 32'h33220102, "wrap_o0");

        // Refill beats store in the same cycle
        cyc(1'b0, 1'b1, 1'b1, mk_addr(1, 0, 26'h0), WORD, 32'h12345678, PAT2, 32'h0, "");
        load(1, 0, 32'h76543210, "prio_o0");
        load(1, 4, 32'hfedcba98, "prio_o4");
        load(1, 8, 32'h89abcdef, "prio_o8");
        load(1, 12, 32'h01234567, "prio_o12");

        // Reset clears everything and drops a same-cycle refill
        @(negedge clk);
        rsn                   = 1'b1;
        bus.mem_wr_data_i     = 1'b1;
        bus.addr_i            = mk_addr(3, 0, 26'h0);
        bus.mem_data_i        = PAT2;
        @(posedge clk);
        #1;
        rsn               = 1'b0;
        bus.mem_wr_data_i = 1'b0;
        for (int unsigned l = 0; l < 4; l++) begin
            load(l, 0, 32'h0, $sformatf("reset_clr_i%0d_o0", l));
            load(l, 8, 32'h0, $sformatf("reset_clr_i%0d_o8", l));
        end

        // Read during write, store then refill
`ifdef SEGRE_DCACHE_BYPASS_EN
        cyc(1'b1, 1'b1, 1'b0, mk_addr(0, 0, 26'h0), WORD, 32'ha5a5a5a5, 128'h0,
            32'ha5a5a5a5, "rdw_store");
        cyc(1'b1, 1'b0, 1'b1, mk_addr(2, 4, 26'h0), WORD, 32'h0, PAT,
            32'h77665544, "rdw_refill");
`else
        cyc(1'b1, 1'b1, 1'b0, mk_addr(0, 0, 26'h0), WORD, 32'ha5a5a5a5, 128'h0,
            32'h0, "rdw_store");
        cyc(1'b1, 1'b0, 1'b1, mk_addr(2, 4, 26'h0), WORD, 32'h0, PAT,
            32'h0, "rdw_refill");
`endif
        load(0, 0, 32'ha5a5a5a5, "rdw_store_after");
        load(2, 4, 32'h77665544, "rdw_refill_after");

        @(negedge clk);
        check("idle_data_o_end", bus.data_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
